// File: rtl/tx_msg_prio_reg_responder.sv
// Responder for the txMsgPrioReg extern: per-message priority table with read-then-update
// semantics, fixed 2-cycle response latency and a DEFAULT_PRIO sweep after reset.
module tx_msg_prio_reg_responder #(
    parameter int unsigned       INDEX_W      = 16,
    parameter int unsigned       PRIO_W       = 8,
    parameter int unsigned       DEPTH        = 1024,
    parameter logic [PRIO_W-1:0] DEFAULT_PRIO = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               net_txMsgPrioReg_req_valid,
    input  logic [INDEX_W-1:0] net_txMsgPrioReg_req_bits_index,
    input  logic               net_txMsgPrioReg_req_bits_update,
    input  logic [PRIO_W-1:0]  net_txMsgPrioReg_req_bits_prio,
    output logic               net_txMsgPrioReg_resp_valid,
    output logic [PRIO_W-1:0]  net_txMsgPrioReg_resp_bits_prio,
    output logic               init_done,
    output logic [15:0]        err_count
);

    localparam int unsigned      AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [INDEX_W:0] DEPTH_EXT = (INDEX_W + 1)'(DEPTH);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [AW-1:0]     r_sweep_cnt;

    logic [PRIO_W-1:0] r_mem [DEPTH];
    logic [PRIO_W-1:0] r_rd_data;

    logic              r_s1_valid;
    logic              r_s1_serviced;
    logic              r_s1_update;
    logic [AW-1:0]     r_s1_addr;
    logic [PRIO_W-1:0] r_s1_prio;

    logic              r_byp_valid;
    logic [AW-1:0]     r_byp_addr;
    logic [PRIO_W-1:0] r_byp_data;

    logic              r_resp_valid;
    logic [PRIO_W-1:0] r_resp_prio;
    logic              r_init_done;
    logic [15:0]       r_err_count;

    logic              w_s0_in_range;
    logic              w_s0_serviced;
    logic [AW-1:0]     w_s0_addr;
    logic              w_s1_wr;
    logic [PRIO_W-1:0] w_s1_old;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_waddr;
    logic [PRIO_W-1:0] w_ram_wdata;

    // Range check at full index width so out-of-range indices never alias into the table.
    assign w_s0_in_range = {1'b0, net_txMsgPrioReg_req_bits_index} < DEPTH_EXT;
    assign w_s0_serviced = net_txMsgPrioReg_req_valid && (r_state == StRun) && w_s0_in_range;
    assign w_s0_addr     = net_txMsgPrioReg_req_bits_index[AW-1:0];

    // The RAM read at the edge of a same-address write returns the old word; the bypass
    // register carries that write into S1.
    assign w_s1_wr  = r_s1_serviced && r_s1_update;
    assign w_s1_old = (r_byp_valid && (r_byp_addr == r_s1_addr)) ? r_byp_data : r_rd_data;

    assign w_ram_we    = reset_n && ((r_state == StInit) || w_s1_wr);
    assign w_ram_waddr = (r_state == StInit) ? r_sweep_cnt : r_s1_addr;
    assign w_ram_wdata = (r_state == StInit) ? DEFAULT_PRIO : r_s1_prio;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if ((r_state == StInit) && (r_sweep_cnt == LAST_ADDR)) begin
            w_state_next = StRun;
        end
    end

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_mem[w_ram_waddr] <= w_ram_wdata;
        end
        if (w_s0_serviced) begin
            r_rd_data <= r_mem[w_s0_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sweep_cnt   <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_serviced <= 1'b0;
            r_s1_update   <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_prio     <= '0;
            r_byp_valid   <= 1'b0;
            r_byp_addr    <= '0;
            r_byp_data    <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_prio   <= '0;
            r_init_done   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            if (r_state == StInit) begin
                r_sweep_cnt <= r_sweep_cnt + AW'(1);
            end
            r_init_done <= (w_state_next == StRun);

            r_s1_valid    <= net_txMsgPrioReg_req_valid;
            r_s1_serviced <= w_s0_serviced;
            r_s1_update   <= net_txMsgPrioReg_req_bits_update;
            r_s1_addr     <= w_s0_addr;
            r_s1_prio     <= net_txMsgPrioReg_req_bits_prio;

            r_byp_valid <= w_s1_wr;
            r_byp_addr  <= r_s1_addr;
            r_byp_data  <= r_s1_prio;

            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_resp_prio <= r_s1_serviced ? w_s1_old : DEFAULT_PRIO;
            end

            if (net_txMsgPrioReg_req_valid && !w_s0_serviced && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign net_txMsgPrioReg_resp_valid     = r_resp_valid;
    assign net_txMsgPrioReg_resp_bits_prio = r_resp_prio;
    assign init_done                       = r_init_done;
    assign err_count                       = r_err_count;

endmodule
